// File: rtl/mr_idecode.sv
// mr_idecode: RV32I instruction-decode stage.
// Decodes a fetched instruction into register indices, a sign-extended
// immediate and an operation class, then holds the result in a valid/ready
// pipeline register for execute. A writeback redirect (flush) discards every
// held and incoming instruction.
// Build option: define MR_IDECODE_SKID_EN for a two-entry skid buffer with a
// registered id_ready. Without it, a single output register is used and
// id_ready is combinational.
module mr_idecode #(
  parameter int XLEN    = 32,
  parameter int IMAXLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IMAXLEN-1:0] inst,
  input  logic [XLEN-1:0]    inst_pc,
  input  logic               inst_valid,
  output logic               id_ready,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_pc,
  output logic [4:0]         ex_rd,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [XLEN-1:0]    ex_imm,
  output logic [3:0]         ex_op,
  output logic [2:0]         ex_funct3,
  output logic               ex_alt
);

  // Operation classes
  localparam logic [3:0] OPC_OP     = 4'd0;
  localparam logic [3:0] OPC_OPIMM  = 4'd1;
  localparam logic [3:0] OPC_LUI    = 4'd2;
  localparam logic [3:0] OPC_AUIPC  = 4'd3;
  localparam logic [3:0] OPC_JAL    = 4'd4;
  localparam logic [3:0] OPC_JALR   = 4'd5;
  localparam logic [3:0] OPC_BRANCH = 4'd6;
  localparam logic [3:0] OPC_LOAD   = 4'd7;
  localparam logic [3:0] OPC_STORE  = 4'd8;
  localparam logic [3:0] OPC_FENCE  = 4'd9;
  localparam logic [3:0] OPC_SYSTEM = 4'd10;
  localparam logic [3:0] OPC_ILL    = 4'd15;

  // One decoded pipeline entry
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      op;
    logic [2:0]      funct3;
    logic            alt;
  } dec_t;

  // Raw instruction fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd_f;
  logic [4:0]      w_rs1_f;
  logic [4:0]      w_rs2_f;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_opcode = inst[6:0];
  assign w_f3     = inst[14:12];
  assign w_f7     = inst[31:25];
  assign w_rd_f   = inst[11:7];
  assign w_rs1_f  = inst[19:15];
  assign w_rs2_f  = inst[24:20];

  // Standard RISC-V immediate formats, sign-extended to XLEN
  assign w_imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign w_imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign w_imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){inst[31]}}, inst[30:12], 12'h000};
  assign w_imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  dec_t w_dec;

  // Combinational decode of the offered instruction; illegal encodings keep
  // only pc and funct3, every other field is zero
  always_comb begin
    w_dec        = '0;
    w_dec.pc     = inst_pc;
    w_dec.funct3 = w_f3;
    w_dec.op     = OPC_ILL;
    case (w_opcode)
      7'b0110011: begin
        if ((w_f7 == 7'h00) ||
            ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))) begin
          w_dec.op  = OPC_OP;
          w_dec.rd  = w_rd_f;
          w_dec.rs1 = w_rs1_f;
          w_dec.rs2 = w_rs2_f;
          w_dec.alt = inst[30];
        end else begin
          w_dec.op  = OPC_ILL;
        end
      end
      7'b0010011: begin
        if ((w_f3 == 3'b001) && (w_f7 != 7'h00)) begin
          w_dec.op  = OPC_ILL;
        end else if ((w_f3 == 3'b101) && (w_f7 != 7'h00) && (w_f7 != 7'h20)) begin
          w_dec.op  = OPC_ILL;
        end else begin
          w_dec.op  = OPC_OPIMM;
          w_dec.rd  = w_rd_f;
          w_dec.rs1 = w_rs1_f;
          w_dec.imm = w_imm_i;
          w_dec.alt = (w_f3 == 3'b101) ? inst[30] : 1'b0;
        end
      end
      7'b0110111: begin
        w_dec.op  = OPC_LUI;
        w_dec.rd  = w_rd_f;
        w_dec.imm = w_imm_u;
      end
      7'b0010111: begin
        w_dec.op  = OPC_AUIPC;
        w_dec.rd  = w_rd_f;
        w_dec.imm = w_imm_u;
      end
      7'b1101111: begin
        w_dec.op  = OPC_JAL;
        w_dec.rd  = w_rd_f;
        w_dec.imm = w_imm_j;
      end
      7'b1100111: begin
        if (w_f3 == 3'b000) begin
          w_dec.op  = OPC_JALR;
          w_dec.rd  = w_rd_f;
          w_dec.rs1 = w_rs1_f;
          w_dec.imm = w_imm_i;
        end else begin
          w_dec.op  = OPC_ILL;
        end
      end
      7'b1100011: begin
        w_dec.op  = OPC_BRANCH;
        w_dec.rs1 = w_rs1_f;
        w_dec.rs2 = w_rs2_f;
        w_dec.imm = w_imm_b;
      end
      7'b0000011: begin
        w_dec.op  = OPC_LOAD;
        w_dec.rd  = w_rd_f;
        w_dec.rs1 = w_rs1_f;
        w_dec.imm = w_imm_i;
      end
      7'b0100011: begin
        w_dec.op  = OPC_STORE;
        w_dec.rs1 = w_rs1_f;
        w_dec.rs2 = w_rs2_f;
        w_dec.imm = w_imm_s;
      end
      7'b0001111: begin
        w_dec.op  = OPC_FENCE;
        w_dec.rd  = w_rd_f;
        w_dec.rs1 = w_rs1_f;
      end
      7'b1110011: begin
        w_dec.op  = OPC_SYSTEM;
        w_dec.rd  = w_rd_f;
        w_dec.rs1 = w_rs1_f;
        w_dec.imm = w_imm_i;
      end
      default: begin
        w_dec.op  = OPC_ILL;
      end
    endcase
  end

  dec_t r_out;
  logic r_ex_valid;
  logic w_accept;
  logic w_out_free;

  assign w_accept   = inst_valid & id_ready;
  assign w_out_free = ~r_ex_valid | ex_ready;

`ifdef MR_IDECODE_SKID_EN
  dec_t r_sk;
  logic r_sk_valid;
  logic r_id_ready;

  // id_ready comes straight from a flop (skid empty); flush only gates it
  assign id_ready = r_id_ready & ~flush;

  // Output + skid registers: a stalled accept parks in skid, skid refills
  // the output on the next drain, flush empties both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_ex_valid <= 1'b0;
      r_sk       <= '0;
      r_sk_valid <= 1'b0;
      r_id_ready <= 1'b1;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
      r_sk_valid <= 1'b0;
      r_id_ready <= 1'b1;
    end else if (w_out_free) begin
      if (r_sk_valid) begin
        r_out      <= r_sk;
        r_ex_valid <= 1'b1;
        r_sk_valid <= 1'b0;
        r_id_ready <= 1'b1;
      end else if (w_accept) begin
        r_out      <= w_dec;
        r_ex_valid <= 1'b1;
      end else begin
        r_ex_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_sk       <= w_dec;
      r_sk_valid <= 1'b1;
      r_id_ready <= 1'b0;
    end else begin
      r_sk_valid <= r_sk_valid;
    end
  end
`else
  // Accept whenever the output register is empty or draining this cycle
  assign id_ready = ~flush & w_out_free;

  // Single output register: load on accept (replacing a draining entry with
  // no bubble), clear valid on a drain without refill, flush drops all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_out      <= w_dec;
      r_ex_valid <= 1'b1;
    end else if (r_ex_valid & ex_ready) begin
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid <= r_ex_valid;
    end
  end
`endif

  assign ex_valid  = r_ex_valid;
  assign ex_pc     = r_out.pc;
  assign ex_rd     = r_out.rd;
  assign ex_rs1    = r_out.rs1;
  assign ex_rs2    = r_out.rs2;
  assign ex_imm    = r_out.imm;
  assign ex_op     = r_out.op;
  assign ex_funct3 = r_out.funct3;
  assign ex_alt    = r_out.alt;

endmodule

// File: doc/mr_idecode.md
# mr_idecode

RV32I instruction-decode stage. Sits directly downstream of the instruction fetch stage, consuming its `inst`/`inst_pc`/`inst_valid`/`id_ready` stream. It decodes each instruction into register indices, a sign-extended immediate and an operation class. Results are held in a valid/ready pipeline register for the execute stage, and the register is flushed on a writeback PC redirect.

## Interface
Parameters (from `rtl/config.svi`):
- `XLEN`, 32: data/PC width.
- `IMAXLEN`, 32: instruction width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst`  in  IMAXLEN  instruction from fetch.
- `inst_pc`  in  XLEN  PC of `inst`.
- `inst_valid`  in  1  fetch offers `inst`.
- `id_ready`  out  1  decode accepts; transfer when `inst_valid & id_ready`.
- `flush`  in  1  writeback redirect (driven by `wb_pc_valid`); discards all held and incoming instructions.
- `ex_valid`  out  1  decoded instruction present.
- `ex_ready`  in  1  execute accepts; transfer when `ex_valid & ex_ready`.
- `ex_pc`  out  XLEN  PC.
- `ex_rd`, `ex_rs1`, `ex_rs2`  out  5 each  register indices.
- `ex_imm`  out  XLEN  sign-extended immediate.
- `ex_op`  out  4  class: 0 OP, 1 OPIMM, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH, 7 LOAD, 8 STORE, 9 FENCE, 10 SYSTEM, 15 ILLEGAL.
- `ex_funct3`  out  3  `inst[14:12]`.
- `ex_alt`  out  1  `inst[30]` for OP and for OPIMM with funct3=101, else 0.

## Operation
- Decode is combinational from `inst`, registered on accept.
- Opcode map (`inst[6:0]`): 0110011 OP, 0010011 OPIMM, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0001111 FENCE, 1110011 SYSTEM.
- Any other opcode, or `inst[1:0]!=11`, decodes as ILLEGAL.
- Additional ILLEGAL cases:
  - OP with funct7 not 0x00/0x20.
  - OP with funct7 0x20 and funct3 not 000/101.
  - OPIMM funct3=001 with funct7!=0x00.
  - OPIMM funct3=101 with funct7 not 0x00/0x20.
  - JALR funct3!=000.
- ILLEGAL entries still flow through with `ex_pc` valid; `ex_rd`, `ex_rs1`, `ex_rs2` and `ex_imm` are 0.
- Immediates, standard RISC-V formats:
  - I: OPIMM, JALR, LOAD, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL, bit 0 = 0.
  - FENCE, OP: 0.
- `ex_rd` is forced to 0 for BRANCH and STORE.
- `ex_rs2` is forced to 0 for everything except OP, BRANCH and STORE.
- `ex_rs1` is forced to 0 for LUI, AUIPC and JAL.
- Flush: on the edge where `flush=1`, all held entries are invalidated and any same-cycle input is dropped. `id_ready=0` while `flush=1`.

## Timing
- Reset values: `ex_valid=0`, all `ex_*` data outputs 0, `id_ready=1` (when `rst_n` deasserts with `flush=0`).
- Latency: an instruction accepted at edge N appears with `ex_valid=1` after edge N.
- Throughput: 1 instruction/cycle while `ex_ready=1`.
- `ex_*` data outputs are stable while `ex_valid & !ex_ready`.
- Simultaneous accept and drain on one edge: the new entry replaces the old, with no bubble.
- Reset mid-operation: state clears asynchronously; the in-flight instruction is lost.

## Configuration
Macro `MR_IDECODE_SKID_EN`.
- Defined: two-entry skid buffer (output register plus skid register).
  - `id_ready` is a flop, equal to skid-empty.
  - An input accepted while the output is stalled goes to skid.
  - Skid moves to output on the next drain.
  - No combinational path from `ex_ready` to `id_ready`.
- Undefined: single output register.
  - `id_ready = !flush & (!ex_valid | ex_ready)`, combinational.

## Test plan
- Reset: hold `rst_n=0` mid-stream -> `ex_valid=0`, `ex_imm=0`. After release, `id_ready=1`.
- `inst=0x00108093` (addi x1,x1,1), pc=0x100 -> next cycle: `ex_op=1`, `ex_rd=1`, `ex_rs1=1`, `ex_rs2=0`, `ex_imm=1`, `ex_pc=0x100`.
- Immediate signs: `0xFE000EE3` (beq x0,x0,-4) -> `ex_op=6`, `ex_imm=0xFFFFFFFC`. `0x800000EF` (jal x1,-1MiB) -> `ex_imm=0xFFF00000`. `0xFE112E23` (sw x1,-4(x2)) -> `ex_imm=0xFFFFFFFC`, `ex_rd=0`.
- Illegal: `0x40109093` (slli with funct7 0x20) and `0x0000007F` -> `ex_op=15`, `ex_imm=0`, `ex_pc` preserved.
- Backpressure: stream 4 instructions with `ex_ready=0` for 3 cycles -> outputs stable while stalled, no loss or duplication, all 4 delivered in order. With `MR_IDECODE_SKID_EN` defined, exactly 2 instructions are accepted before `id_ready=0`.
- Flush: output and skid full, assert `flush` with `inst_valid=1` -> next cycle `ex_valid=0`. The flushed and same-cycle instructions never appear; the first instruction after flush decodes normally.
